// File: rtl/repdigit_sum_engine.sv
// repdigit_sum_engine: sums and counts the n-digit integers <= bound that are
// a digit block repeated r times (mode 0), or repeated any r>=2 times
// (mode 1, Moebius inclusion-exclusion over the divisors of n).
module repdigit_sum_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_DIGS   = 18,
    parameter int DW         = $clog2(MAX_DIGS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_bound,
    input  logic [DW-1:0]             in_n_digs,
    input  logic [DW-1:0]             in_reps,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_sum,
    output logic [DATA_WIDTH-1:0]     out_count,
    output logic                      out_err
);

    localparam int AW = 2 * DATA_WIDTH + 2;      // accumulator width
    localparam int RW = DW + 1;                  // r runs up to n+1
    localparam int CW = $clog2(DATA_WIDTH + 1) + 1;
    localparam logic [DW-1:0] MAXD = DW'(MAX_DIGS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEL, ST_BASE, ST_DIV, ST_SERIES, ST_MUL, ST_ACC, ST_DONE
    } state_t;

    state_t state_reg, state_next;

    // Constant powers of ten, 10^0 .. 10^MAX_DIGS
    function automatic logic [DATA_WIDTH-1:0] pow10_f(input int k);
        logic [DATA_WIDTH-1:0] v;
        v = DATA_WIDTH'(1);
        for (int i = 0; i < k; i++) v = v * DATA_WIDTH'(10);
        return v;
    endfunction

    logic [DATA_WIDTH-1:0] pow10 [0:MAX_DIGS];
    genvar gi;
    generate
        for (gi = 0; gi <= MAX_DIGS; gi++) begin : g_pow10
            assign pow10[gi] = pow10_f(gi);
        end
    endgenerate

    // Inclusion-exclusion weight -mu(r): 2'b01 = +1, 2'b10 = -1, 2'b00 = skip
    function automatic logic [1:0] weight_f(input logic [RW-1:0] r);
        case (32'(r))
            2, 3, 5, 7, 11, 13, 17, 19: weight_f = 2'b01;
            6, 10, 14, 15:              weight_f = 2'b10;
            default:                    weight_f = 2'b00;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0]   bound_reg, base_reg, p_reg, step_reg, q_reg, rem_reg, nn_reg;
    logic [DATA_WIDTH:0]     s_reg;
    logic [DW-1:0]           n_reg, b_reg;
    logic [RW-1:0]           r_reg;
    logic [CW-1:0]           cnt_reg;
    logic                    mode_reg, empty_reg, err_reg;
    logic [2*DATA_WIDTH-1:0] term_reg;
    logic signed [AW-1:0]    acc_sum_reg, acc_cnt_reg;

    logic [RW-1:0]           r_safe, n_ext;
    logic [DW-1:0]           b_calc;
    logic [1:0]              w_cur;
    logic                    mod_nz, illegal, sel_done, sel_skip, sel_go;
    logic                    base_last, div_last;
    logic [DATA_WIDTH:0]     trial, diff;
    logic [DATA_WIDTH-1:0]   cap, lb, ub;
    logic [2*DATA_WIDTH:0]   sn;

    // Combinational helpers: factor selection, divider step, series bounds
    always_comb begin
        n_ext    = RW'(n_reg);
        r_safe   = (r_reg == '0) ? RW'(1) : r_reg;
        mod_nz   = (n_ext % r_safe) != '0;
        b_calc   = DW'(n_ext / r_safe);
        w_cur    = weight_f(r_reg);
        illegal  = (n_reg == '0) || (n_reg > MAXD) ||
                   (!mode_reg && ((r_reg < RW'(2)) || (r_reg > n_ext) || mod_nz));
        sel_done = illegal || (mode_reg && (r_reg > n_ext));
        sel_skip = !sel_done && mode_reg && (mod_nz || (w_cur == 2'b00));
        sel_go   = !sel_done && !sel_skip;
        base_last = (cnt_reg == CW'(r_reg) - CW'(1));
        div_last  = (cnt_reg == CW'(DATA_WIDTH - 1));
        trial    = {rem_reg, q_reg[DATA_WIDTH-1]};
        diff     = trial - {1'b0, base_reg};
        cap      = pow10[b_reg] - DATA_WIDTH'(1);
        lb       = pow10[b_reg - DW'(1)];
        ub       = (q_reg < cap) ? q_reg : cap;
        sn       = (2*DATA_WIDTH+1)'(s_reg) * (2*DATA_WIDTH+1)'(nn_reg);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (in_valid) state_next = ST_SEL;
            ST_SEL:    if (sel_done) state_next = ST_DONE;
                       else if (sel_go) state_next = ST_BASE;
            ST_BASE:   if (base_last) state_next = ST_DIV;
            ST_DIV:    if (div_last) state_next = ST_SERIES;
            ST_SERIES: state_next = ST_MUL;
            ST_MUL:    state_next = ST_ACC;
            ST_ACC:    state_next = mode_reg ? ST_SEL : ST_DONE;
            ST_DONE:   if (out_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch request, build B, divide, form and accumulate terms
    always_ff @(posedge clock) begin
        if (reset) begin
            bound_reg   <= '0;
            n_reg       <= '0;
            r_reg       <= '0;
            b_reg       <= '0;
            mode_reg    <= 1'b0;
            cnt_reg     <= '0;
            base_reg    <= '0;
            p_reg       <= '0;
            step_reg    <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            s_reg       <= '0;
            nn_reg      <= '0;
            empty_reg   <= 1'b0;
            term_reg    <= '0;
            acc_sum_reg <= '0;
            acc_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    bound_reg   <= in_bound;
                    n_reg       <= in_n_digs;
                    mode_reg    <= in_mode;
                    r_reg       <= in_mode ? RW'(2) : RW'(in_reps);
                    acc_sum_reg <= '0;
                    acc_cnt_reg <= '0;
                    err_reg     <= 1'b0;
                end
                ST_SEL: begin
                    if (illegal) err_reg <= 1'b1;
                    if (sel_skip) r_reg <= r_reg + RW'(1);
                    if (sel_go) begin
                        b_reg    <= b_calc;
                        step_reg <= pow10[b_calc];
                        base_reg <= '0;
                        p_reg    <= DATA_WIDTH'(1);
                        cnt_reg  <= '0;
                    end
                end
                ST_BASE: begin
                    base_reg <= base_reg + p_reg;
                    p_reg    <= p_reg * step_reg;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (base_last) begin
                        cnt_reg <= '0;
                        rem_reg <= '0;
                        q_reg   <= bound_reg;
                    end
                end
                ST_DIV: begin
                    if (!diff[DATA_WIDTH]) begin
                        rem_reg <= diff[DATA_WIDTH-1:0];
                        q_reg   <= {q_reg[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= trial[DATA_WIDTH-1:0];
                        q_reg   <= {q_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg + CW'(1);
                end
                ST_SERIES: begin
                    s_reg     <= {1'b0, lb} + {1'b0, ub};
                    nn_reg    <= ub - lb + DATA_WIDTH'(1);
                    empty_reg <= ub < lb;
                end
                ST_MUL: begin
                    term_reg <= empty_reg ? '0
                              : (2*DATA_WIDTH)'(base_reg) * sn[2*DATA_WIDTH:1];
                end
                ST_ACC: begin
                    if (!empty_reg) begin
                        if (mode_reg && w_cur[1]) begin
                            acc_sum_reg <= acc_sum_reg - $signed(AW'(term_reg));
                            acc_cnt_reg <= acc_cnt_reg - $signed(AW'(nn_reg));
                        end else begin
                            acc_sum_reg <= acc_sum_reg + $signed(AW'(term_reg));
                            acc_cnt_reg <= acc_cnt_reg + $signed(AW'(nn_reg));
                        end
                    end
                    if (mode_reg) r_reg <= r_reg + RW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign out_sum   = acc_sum_reg[2*DATA_WIDTH-1:0];
    assign out_count = acc_cnt_reg[DATA_WIDTH-1:0];
    assign out_err   = err_reg;

    // Accumulator headroom bits and the dropped halving bit are not outputs
    logic unused_bits;
    assign unused_bits = ^{acc_sum_reg[AW-1:2*DATA_WIDTH],
                           acc_cnt_reg[AW-1:DATA_WIDTH], sn[0]};

endmodule

// File: tb/tb_repdigit_sum_engine.sv
// Directed testbench for repdigit_sum_engine (default parameters, W=64).
module tb_repdigit_sum_engine;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_bound;
    logic [4:0]    in_n_digs;
    logic [4:0]    in_reps;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_sum;
    logic [63:0]   out_count;
    logic          out_err;

    int total = 0;
    int bad   = 0;

    repdigit_sum_engine dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bound  (in_bound),
        .in_n_digs (in_n_digs),
        .in_reps   (in_reps),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Issue one request, check result, latency, and optional back-pressure hold.
    task automatic run_req(input string tag, input logic [63:0] bound, input int n,
                           input int r, input bit mode, input logic [127:0] es,
                           input logic [63:0] ec, input bit ee, input int el,
                           input int hold);
        int lat;
        int busy_ready;
        @(negedge clock);
        check_val({tag, ".in_ready"}, 128'(in_ready), 128'd1);
        in_valid  = 1'b1;
        in_bound  = bound;
        in_n_digs = 5'(n);
        in_reps   = 5'(r);
        in_mode   = mode;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_bound  = {$urandom, $urandom};
        in_n_digs = 5'($urandom);
        in_reps   = 5'($urandom);
        in_mode   = 1'($urandom);
        lat = 1;
        busy_ready = 0;
        while (!out_valid && lat < 2000) begin
            if (in_ready) busy_ready++;
            @(posedge clock);
            #1;
            lat++;
        end
        check_val({tag, ".latency"}, 128'(lat), 128'(el));
        check_val({tag, ".busy_ready"}, 128'(busy_ready), 128'd0);
        check_val({tag, ".sum"}, out_sum, es);
        check_val({tag, ".count"}, 128'(out_count), 128'(ec));
        check_val({tag, ".err"}, 128'(out_err), 128'(ee));
        $display("req %s: n=%0d r=%0d mode=%0d sum=%0d count=%0d err=%0d lat=%0d",
                 tag, n, r, mode, out_sum, out_count, out_err, lat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check_val({tag, ".hold_valid"}, 128'(out_valid), 128'd1);
            check_val({tag, ".hold_sum"}, out_sum, es);
            check_val({tag, ".hold_count"}, 128'(out_count), 128'(ec));
            check_val({tag, ".hold_ready"}, 128'(in_ready), 128'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_val({tag, ".ret_ready"}, 128'(in_ready), 128'd1);
        check_val({tag, ".ret_valid"}, 128'(out_valid), 128'd0);
    endtask

    initial begin
        int seen_valid;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bound  = '0;
        in_n_digs = '0;
        in_reps   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst.in_ready", 128'(in_ready), 128'd1);
        check_val("rst.out_valid", 128'(out_valid), 128'd0);
        check_val("rst.sum", out_sum, 128'd0);
        check_val("rst.count", 128'(out_count), 128'd0);
        check_val("rst.err", 128'(out_err), 128'd0);
        @(negedge clock);
        reset = 1'b0;

        //       tag          bound                     n   r  m  sum                               count        err lat  hold
        run_req("basic",     64'd22,                    2,  2, 0, 128'd33,                          64'd2,       0,  71, 0);
        run_req("m1_n3",     64'd999,                   3,  0, 1, 128'd4995,                        64'd9,       0,  74, 0);
        run_req("m1_n6",     64'd999999,                6,  0, 1, 128'd539589960,                   64'd981,     0, 219, 0);
        run_req("empty",     64'd999,                   4,  2, 0, 128'd0,                           64'd0,       0,  71, 0);
        run_req("ill_r4",    64'd999999,                6,  4, 0, 128'd0,                           64'd0,       1,   2, 0);
        run_req("m0_n6r3",   64'd999999,                6,  3, 0, 128'd49545405,                    64'd90,      0,  72, 0);
        run_req("m0_part",   64'd500000,                6,  2, 0, 128'd119919800,                   64'd400,     0,  71, 0);
        run_req("m1_n2",     64'd55,                    2,  0, 1, 128'd165,                         64'd5,       0,  72, 0);
        run_req("m1_n1",     64'd9,                     1,  0, 1, 128'd0,                           64'd0,       0,   2, 0);
        run_req("ill_n0",    64'd9,                     0,  0, 1, 128'd0,                           64'd0,       1,   2, 0);
        run_req("ill_n19",   64'd9,                    19, 19, 0, 128'd0,                           64'd0,       1,   2, 0);
        run_req("ill_r1",    64'd9999,                  4,  1, 0, 128'd0,                           64'd0,       1,   2, 0);
        run_req("ill_rgtn",  64'd999999,                6,  7, 0, 128'd0,                           64'd0,       1,   2, 0);
        run_req("wide18",    64'd999999999999999999,   18,  2, 0, 128'd495000000044999999550000000, 64'd900000000, 0, 71, 0);
        run_req("backpr",    64'd99,                    2,  2, 0, 128'd495,                         64'd9,       0,  71, 10);

        // Reset in the middle of the divider phase discards the request
        @(negedge clock);
        in_valid  = 1'b1;
        in_bound  = 64'd22;
        in_n_digs = 5'd2;
        in_reps   = 5'd2;
        in_mode   = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_val("midrst.in_ready", 128'(in_ready), 128'd1);
        check_val("midrst.out_valid", 128'(out_valid), 128'd0);
        check_val("midrst.sum", out_sum, 128'd0);
        check_val("midrst.count", 128'(out_count), 128'd0);
        check_val("midrst.err", 128'(out_err), 128'd0);
        seen_valid = 0;
        repeat (80) begin
            @(posedge clock);
            #1;
            if (out_valid) seen_valid++;
        end
        check_val("midrst.discard", 128'(seen_valid), 128'd0);
        $display("req midrst: reset during divide, valid_seen=%0d", seen_valid);

        run_req("after_rst", 64'd22,                    2,  2, 0, 128'd33,                          64'd2,       0,  71, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/repdigit_sum_engine.md
# repdigit_sum_engine

- Computes the sum and count of all `n_digs`-digit integers ≤ `in_bound` that are a digit block repeated `reps` times.
  - Mode 0 uses exactly one repeat factor.
  - Mode 1 covers any repeat factor ≥2, combined by Möbius inclusion-exclusion over the divisors of `n_digs`.
- It is the parametrised, handshaked successor to the fixed-factor group/primitive counters in the invalid-ID range solver.
- It sits between the range splitter, which supplies one bound per digit count, and the top-level accumulator.

## Interface

**Parameters**
- `DATA_WIDTH`, default 64: width of the bound, base and count. Must satisfy 10^`MAX_DIGS` < 2^`DATA_WIDTH`.
- `MAX_DIGS`, default 18: largest legal `n_digs`. Must be ≤ 20, the extent of the Möbius table.
- `DW`, default `$clog2(MAX_DIGS+1)`: width of the digit-count and repeat-factor fields.

**Ports**
- `clock` input 1: the single clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: engine idle and able to accept.
- `in_bound` input `DATA_WIDTH`: inclusive upper bound.
- `in_n_digs` input `DW`: digit count n.
- `in_reps` input `DW`: repeat factor r. Used in mode 0 only.
- `in_mode` input 1: 0 = exact r; 1 = any r≥2.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output 2*`DATA_WIDTH`: sum of the qualifying integers.
- `out_count` output `DATA_WIDTH`: number of qualifying integers.
- `out_err` output 1: the request was illegal.

## Operation

**Per-factor term**, with b = n/r:
- B = Σ_{k=0}^{r-1} 10^(b·k)
- lb = 10^(b-1)
- ub = min(10^b − 1, ⌊bound/B⌋)
- If ub < lb, the term and its count are 0.
- Otherwise term = B·((lb+ub)·(ub−lb+1) >> 1) and count = ub−lb+1.

**Mode 0:** result = the term for r = `in_reps`.

**Mode 1:** result = Σ over divisors r≥2 of n of w(r)·term(r), where w(r) = −μ(r).
- w = +1 for r ∈ {2,3,5,7,11,13,17,19}.
- w = −1 for r ∈ {6,10,14,15}.
- w = 0 for r ∈ {4,8,9,12,16,18,20}, which are skipped.
- The count accumulates with the same weights.

**Arithmetic**
- Accumulators are signed, 2*`DATA_WIDTH`+2 bits.
- Final values are non-negative and are truncated to the output widths.
- Division is a restoring divider: 1 quotient bit per cycle, `DATA_WIDTH` cycles.

**Illegal requests** set `out_err`=1, `out_sum`=0, `out_count`=0. A request is illegal when any of these holds:
- n = 0 or n > `MAX_DIGS`;
- mode 0 with r < 2;
- mode 0 with r > n;
- mode 0 with n mod r ≠ 0.

**State machine**
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch all inputs, clear the accumulators, set r = `in_reps` (mode 0) or r = 2 (mode 1), and go to SEL.
- **SEL**
  - Illegal request → DONE.
  - Mode 1 with r > n → DONE.
  - Mode 1 with n mod r ≠ 0 or w(r) = 0 → r++ and stay in SEL.
  - Otherwise → BASE.
- **BASE**
  - Runs r cycles. Each cycle: B += p; p ×= 10^b, with p starting at 1.
- **DIV**
  - Runs `DATA_WIDTH` cycles computing ⌊bound/B⌋.
- **SERIES**
  - Registers S = lb+ub and N = ub−lb+1.
  - Flags the term empty if ub < lb.
- **MUL**
  - Registers B·((S·N) >> 1), or 0 if the term is empty.
- **ACC**
  - Adds ±term and ±N (or 0 if empty) to the accumulators.
  - Mode 0 → DONE. Mode 1 → r++ and go to SEL.
- **DONE**
  - `out_valid`=1; outputs are held stable.
  - On `out_ready`, go to IDLE.

## Timing

**Reset**
- Asserting `reset` in any state forces IDLE on the next edge.
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_err`=0.
- An in-flight request is discarded and never produces a result.

**Latency** (handshake cycle = cycle 0)
- Legal mode 0: `out_valid` first high in cycle r+`DATA_WIDTH`+5.
- Illegal request: `out_valid` in cycle 2.
- Mode 1: `out_valid` in cycle 1 + n + Σ over contributing r of (r + `DATA_WIDTH` + 3).

**Handshakes**
- `in_ready` is high only in IDLE.
- The engine is non-pipelined: one request in flight at a time.
- The output handshake completes on `out_valid` & `out_ready`. `in_ready` rises the following cycle; there is no same-cycle turnaround.
- Back-pressure: DONE is held indefinitely and the outputs must not change while `out_valid`=1.
- Inputs are sampled only at the input handshake. Changes on the input ports afterwards have no effect.

## Test plan

- **Basic mode 0:** mode 0, n=2, r=2, bound=22 → `out_sum`=33, `out_count`=2, `out_err`=0, `out_valid` at cycle 71 (W=64).
- **Single-factor mode 1:** mode 1, n=3, bound=999 → `out_sum`=4995, `out_count`=9.
- **Inclusion-exclusion:** mode 1, n=6, bound=999999.
  - Expected: `out_sum`=539589960, `out_count`=981.
  - Check terms +495044550, +49545405 and −4999995 internally.
- **Empty range:** mode 0, n=4, r=2, bound=999 → ub=9 < lb=10, so `out_sum`=0, `out_count`=0, `out_err`=0, full latency.
- **Illegal request:** mode 0, n=6, r=4 → `out_err`=1, sum and count 0, `out_valid` at cycle 2.
- **Back-pressure and reset:**
  - Hold `out_ready`=0 for 10 cycles → outputs stable and `in_ready`=0 throughout.
  - Assert `reset` mid-DIV → next cycle is IDLE with all outputs 0.
  - A fresh request after reset returns the correct result.
